// File: rtl/stack_call_ctrl.sv
// Return-address stack controller: turns CALL/RET into push/pop cycles and a PC load strobe.
// Optional depth / high-water counters under STACK_CALL_DEPTH_EN.
module stack_call_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           call,
    input  logic                           ret,
    input  logic [WIDTH-1:0]               pc_in,
    input  logic [WIDTH-1:0]               target,
    output logic                           busy,
    output logic                           pc_load,
    output logic [WIDTH-1:0]               pc_next,
    output logic                           fault,
    output logic [1:0]                     fault_code,
    output logic                           stk_push,
    output logic                           stk_pop,
    output logic [WIDTH-1:0]               stk_data,
    input  logic [WIDTH-1:0]               stk_dout,
    input  logic                           stk_full,
    input  logic                           stk_empty
`ifdef STACK_CALL_DEPTH_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic [$clog2(DEPTH+1)-1:0]     depth_max
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP    = 3'd2,
        LOAD_R = 3'd3,
        LOAD   = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_from_stk;
    logic [WIDTH-1:0] w_ret_addr;

    assign w_ret_addr = pc_in + WIDTH'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_from_stk <= 1'b0;
            busy       <= 1'b0;
            pc_load    <= 1'b0;
            pc_next    <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_data   <= '0;
        end else begin
            fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Simultaneous call+ret is rejected outright, ahead of full/empty checks.
                    if (call && ret) begin
                        fault      <= 1'b1;
                        fault_code <= 2'b11;
                    end else if (call) begin
                        if (stk_full) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                        end else begin
                            stk_data <= w_ret_addr;
                            pc_next  <= target;
                            stk_push <= 1'b1;
                            busy     <= 1'b1;
                            r_state  <= PUSH;
                        end
                    end else if (ret) begin
                        if (stk_empty) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b10;
                        end else begin
                            stk_pop <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= POP;
                        end
                    end
                end
                PUSH: begin
                    stk_push <= 1'b0;
                    pc_load  <= 1'b1;
                    r_state  <= LOAD;
                end
                POP: begin
                    stk_pop    <= 1'b0;
                    r_from_stk <= 1'b1;
                    r_state    <= LOAD_R;
                end
                LOAD_R: begin
                    // Stack output is valid only now, one cycle after the pop edge.
                    if (r_from_stk) pc_next <= stk_dout;
                    pc_load <= 1'b1;
                    r_state <= LOAD;
                end
                LOAD: begin
                    pc_load    <= 1'b0;
                    busy       <= 1'b0;
                    r_from_stk <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    stk_push <= 1'b0;
                    stk_pop  <= 1'b0;
                    pc_load  <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

`ifdef STACK_CALL_DEPTH_EN
    localparam int DW = $clog2(DEPTH+1);

    logic [DW-1:0] w_depth_nxt;

    always_comb begin
        w_depth_nxt = depth;
        if (r_state == PUSH && depth != DW'(DEPTH))
            w_depth_nxt = depth + DW'(1);
        else if (r_state == POP && depth != '0)
            w_depth_nxt = depth - DW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth     <= '0;
            depth_max <= '0;
        end else begin
            depth <= w_depth_nxt;
            if (w_depth_nxt > depth_max) depth_max <= w_depth_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Bench for stack_call_ctrl with a behavioural 4x10 stack; scoreboard queues hold expected
// push data and PC loads.
module tb_stack_call_ctrl;
    localparam int W = 4;
    localparam int D = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         call = 1'b0, ret = 1'b0;
    logic [W-1:0] pc_in = '0, target = '0;
    logic         busy, pc_load, fault, stk_push, stk_pop, stk_full, stk_empty;
    logic [W-1:0] pc_next, stk_data;
    logic [W-1:0] stk_dout;
    logic [1:0]   fault_code;
`ifdef STACK_CALL_DEPTH_EN
    logic [3:0]   depth, depth_max;
`endif

    stack_call_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .pc_in(pc_in), .target(target),
        .busy(busy), .pc_load(pc_load), .pc_next(pc_next), .fault(fault), .fault_code(fault_code),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data), .stk_dout(stk_dout),
        .stk_full(stk_full), .stk_empty(stk_empty)
`ifdef STACK_CALL_DEPTH_EN
        , .depth(depth), .depth_max(depth_max)
`endif
    );

    always #5 clk = ~clk;

    // behavioural stack: registered data_out holds the popped value after the pop edge
    logic [W-1:0] mem [D];
    int           sp;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp       <= 0;
            stk_dout <= '0;
        end else if (stk_push && sp < D) begin
            mem[sp] <= stk_data;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
        end
    end
    assign stk_full  = (sp == D);
    assign stk_empty = (sp == 0);

    int n_run = 0, n_fail = 0;
    int push_cnt = 0, pop_cnt = 0;
    logic [W-1:0] exp_pc_q[$], exp_dat_q[$], rs_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (stk_push || stk_pop) chk("push_pop_excl", {stk_push, stk_pop} == 2'b11, 0);
            if (stk_push) begin
                push_cnt++;
                chk("push_while_full", stk_full, 0);
                if (exp_dat_q.size() == 0) chk("push_unexpected", 1, 0);
                else chk("stk_data", stk_data, exp_dat_q.pop_front());
            end
            if (stk_pop) begin
                pop_cnt++;
                chk("pop_while_empty", stk_empty, 0);
            end
            if (pc_load) begin
                if (exp_pc_q.size() == 0) chk("pc_load_unexpected", 1, 0);
                else chk("pc_next", pc_next, exp_pc_q.pop_front());
            end
        end
    end

    task automatic wait_load(input string tag, input int lat, input bit pulse);
        int n;
        bit seen;
        seen = 0;
        @(negedge clk);
        call = 0; ret = 0; n = 1;
        if (pulse) begin
            chk({tag, "_busy"}, busy, 1);
            call = 1; pc_in = 4'h7; target = 4'h9;
        end
        while (!seen && n < 8) begin
            if (pc_load) seen = 1;
            else begin
                @(negedge clk);
                n++;
                if (pulse && n == 2) call = 0;
            end
        end
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_lat"}, n, lat);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, pc_load}, 0);
    endtask

    task automatic do_call(input logic [W-1:0] pc, input logic [W-1:0] tgt, input bit pulse);
        logic [W-1:0] ra;
        ra = pc + 4'd1;
        @(negedge clk);
        call = 1; pc_in = pc; target = tgt;
        exp_dat_q.push_back(ra);
        exp_pc_q.push_back(tgt);
        rs_q.push_back(ra);
        wait_load("call", 2, pulse);
    endtask

    task automatic do_ret();
        @(negedge clk);
        ret = 1;
        if (rs_q.size() != 0) exp_pc_q.push_back(rs_q.pop_back());
        wait_load("ret", 3, 0);
    endtask

    task automatic do_fault(input bit c, input bit r, input logic [1:0] code);
        int pu0, po0;
        pu0 = push_cnt; po0 = pop_cnt;
        @(negedge clk);
        call = c; ret = r; pc_in = 4'h2; target = 4'h3;
        @(negedge clk);
        call = 0; ret = 0;
        chk("fault_strobe", fault, 1);
        chk("fault_code", fault_code, code);
        chk("fault_busy", busy, 0);
        @(negedge clk);
        chk("fault_1cyc", fault, 0);
        chk("fault_code_held", fault_code, code);
        chk("fault_no_stack", (push_cnt - pu0) + (pop_cnt - po0), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        exp_pc_q.delete(); exp_dat_q.delete(); rs_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {busy, pc_load, fault, stk_push, stk_pop}, 0);
        chk("rst_data", {pc_next, stk_data, fault_code}, 0);
`ifdef STACK_CALL_DEPTH_EN
        chk("rst_depth", {depth, depth_max}, 0);
`endif
        reset = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pu0;
        // T1: reset, then abort a call mid-PUSH
        do_reset();
        @(negedge clk);
        call = 1; pc_in = 4'h3; target = 4'hA;
        exp_dat_q.push_back(4'h4);
        @(negedge clk);
        call = 0;
        chk("abort_in_push", stk_push, 1);
        #1 reset = 0;
        #1;
        chk("abort_push_low", {stk_push, busy}, 0);
        exp_pc_q.delete();
        @(negedge clk);
        chk("abort_no_push", sp, 0);
        reset = 1;

        // T5: faults on empty stack
        do_fault(0, 1, 2'b10);
        do_fault(1, 1, 2'b11);

        // T2: single call and its return
        do_call(4'h3, 4'hA, 0);
        chk("t2_depth_sp", sp, 1);
        do_ret();

        // T3: return addresses with wrap F+1 -> 0
        do_call(4'h1, 4'h8, 0);
        do_call(4'h5, 4'hB, 0);
        do_call(4'hF, 4'hC, 0);
        do_ret(); do_ret(); do_ret();
        chk("t3_empty", sp, 0);

        // T4: fill, overflow, drain
        for (int i = 0; i < D; i++) do_call(4'(i), 4'(15 - i), 0);
        chk("t4_full", stk_full, 1);
        do_fault(1, 0, 2'b01);
        chk("t4_sp_kept", sp, D);
        chk("t4_top_kept", mem[D-1], 4'hA);
        for (int i = 0; i < D; i++) do_ret();
        chk("t4_drained", sp, 0);

        // T6: call pulse while busy is ignored; depth tracking
        do_reset();
        pu0 = push_cnt;
        do_call(4'h2, 4'h4, 1);
        chk("t6_one_push", push_cnt - pu0, 1);
        do_call(4'h6, 4'h1, 0);
        do_call(4'hD, 4'h0, 0);
`ifdef STACK_CALL_DEPTH_EN
        chk("t6_depth3", depth, 3);
`endif
        do_ret(); do_ret();
`ifdef STACK_CALL_DEPTH_EN
        chk("t6_depth1", depth, 1);
        chk("t6_depth_max", depth_max, 3);
`endif
        chk("t6_sp", sp, 1);
        chk("t6_q_empty", exp_pc_q.size() + exp_dat_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
